// File: rtl/mem_port_if.sv
// mem_port_if: request/response bus between a requester (master) and mem_port_ctrl (slave).
interface mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-outstanding byte-addressed data memory port with fixed read latency.
// Define MEM_PORT_CTRL_ALIGN_CHECK_EN to also fault misaligned accesses.
module mem_port_ctrl #(
    parameter int MEMSIZE    = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic      clk,
    input  logic      reset,
    mem_port_if.slave bus,
    output logic      busy
);
    localparam int AW = $clog2(MEMSIZE);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state;
    logic [1:0]  cnt;
    logic        we_q, sg_q;
    logic [1:0]  sz_q;
    logic [63:0] addr_q, wdata_q;
    logic [7:0]  mem [MEMSIZE];
    logic        accept, enter_resp, c_we, c_sg, oob, fault;
    logic [1:0]  c_sz;
    logic [3:0]  nbytes;
    logic [64:0] end_addr;
    logic [63:0] c_addr, c_wdata, raw, rdata;
    assign accept     = state == IDLE && bus.req_ready && bus.req_valid;
    assign enter_resp = (state == ACCESS) ? (cnt == 2'd0) : (accept && RD_LATENCY == 1);
    // In IDLE the live request is used so a latency-1 access can commit on its accept edge.
    assign c_we    = (state == IDLE) ? bus.req_we     : we_q;
    assign c_sg    = (state == IDLE) ? bus.req_signed : sg_q;
    assign c_sz    = (state == IDLE) ? bus.req_size   : sz_q;
    assign c_addr  = (state == IDLE) ? bus.req_addr   : addr_q;
    assign c_wdata = (state == IDLE) ? bus.req_wdata  : wdata_q;
    assign nbytes   = 4'd1 << c_sz;
    assign end_addr = {1'b0, c_addr} + 65'(nbytes);
    assign oob      = end_addr > 65'(MEMSIZE);
`ifdef MEM_PORT_CTRL_ALIGN_CHECK_EN
    assign fault = oob || (c_addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
`else
    assign fault = oob;
`endif
    always_comb begin
        raw = '0;
        for (int i = 0; i < 8; i++)
            if (i < int'(nbytes) && !fault) raw[8*i +: 8] = mem[c_addr[AW-1:0] + AW'(i)];
    end
    assign rdata = (c_sz == 2'd0) ? {{56{c_sg & raw[7]}},  raw[7:0]}  :
                   (c_sz == 2'd1) ? {{48{c_sg & raw[15]}}, raw[15:0]} :
                   (c_sz == 2'd2) ? {{32{c_sg & raw[31]}}, raw[31:0]} : raw;
    // Memory has no reset; contents survive controller resets.
    always_ff @(posedge clk)
        if (enter_resp && c_we && !fault && !reset)
            for (int i = 0; i < 8; i++)
                if (i < int'(nbytes)) mem[c_addr[AW-1:0] + AW'(i)] <= c_wdata[8*i +: 8];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            we_q          <= 1'b0;
            sg_q          <= 1'b0;
            sz_q          <= 2'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            busy          <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (accept) begin
                        we_q          <= bus.req_we;
                        sg_q          <= bus.req_signed;
                        sz_q          <= bus.req_size;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        state         <= ACCESS;
                        cnt           <= (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;
                        busy          <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end else bus.req_ready <= 1'b1;
                ACCESS:
                    if (cnt != 2'd0) cnt <= cnt - 2'd1;
                RESP:
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_fault <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                state         <= RESP;
                bus.rsp_valid <= 1'b1;
                bus.rsp_rdata <= c_we ? '0 : rdata;
                bus.rsp_fault <= fault;
            end
        end
endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter MEMSIZE, default 1024, meaning data memory size in bytes.
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning cycles from request acceptance to first rsp_valid cycle; legal range 1..4.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_size  input  2  access size: 0 = 1B, 1 = 2B, 2 = 4B, 3 = 8B.
REQ-009 SHALL have port req_signed  input  1  sign-extend read data (reads only).
REQ-010 SHALL have port req_addr  input  64  byte address.
REQ-011 SHALL have port req_wdata  input  64  write data, low-order bytes used.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-014 SHALL have port rsp_rdata  output  64  read data, 0 for writes and faults.
REQ-015 SHALL have port rsp_fault  output  1  access rejected.
REQ-016 SHALL have port busy  output  1  state != IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP; one outstanding request only.
REQ-018 SHALL assert req_ready only in IDLE; accept on the clk edge where req_valid && req_ready; latch we, size, signed, addr, wdata at that edge.
REQ-019 SHALL go IDLE->ACCESS on accept when RD_LATENCY > 1 and IDLE->RESP directly when RD_LATENCY == 1.
REQ-020 SHALL stay in ACCESS for RD_LATENCY-1 cycles using a down-counter, then enter RESP.
REQ-021 SHALL commit writes and capture read data on the edge entering RESP; memory is little-endian (byte at addr = bits [7:0]).
REQ-022 SHALL write only the 2^req_size addressed bytes and leave all other bytes unchanged.
REQ-023 SHALL return read data zero-extended when req_signed = 0 and sign-extended from the top accessed byte when req_signed = 1.
REQ-024 SHALL flag a fault when addr + 2^size > MEMSIZE (computed without 64-bit wrap); a faulting access does not touch memory, returns rsp_rdata = 0 and rsp_fault = 1, and keeps the same latency.
REQ-025 SHALL hold rsp_valid, rsp_rdata and rsp_fault stable in RESP until rsp_valid && rsp_ready, then go to IDLE.
REQ-026 SHALL keep req_ready low in the cycle of the RESP->IDLE handshake; next accept earliest one cycle later (no same-cycle back-to-back).
REQ-027 SHALL drive rsp_rdata = 0 and rsp_fault = 0 whenever rsp_valid = 0.
REQ-028 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-029 SHALL on reset force IDLE, counter = 0, req_ready = 0 while reset is high, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, busy = 0.
REQ-030 SHALL discard an in-flight request on reset mid-operation; a write not yet committed is never committed.
REQ-031 SHALL NOT clear memory contents on reset.

Configuration
REQ-032 SHALL, with MEM_PORT_CTRL_ALIGN_CHECK_EN defined, also fault when addr mod 2^size != 0, with the same fault behaviour as REQ-024.
REQ-033 SHALL, without MEM_PORT_CTRL_ALIGN_CHECK_EN, perform misaligned accesses byte-by-byte with no alignment fault.

Verification
REQ-034 SHALL verify: RD_LATENCY=2, write size 3 addr 0x10 data 0x1122334455667788, then read size 3 addr 0x10 -> rsp_rdata 0x1122334455667788, fault 0, rsp_valid 2 cycles after each accept.
REQ-035 SHALL verify: read size 0 addr 0x10 signed=1 -> 0x0000000000000088 zero-ext vs 0xFFFFFFFFFFFFFF88 signed; read size 1 addr 0x16 -> 0x1122.
REQ-036 SHALL verify: write size 2 addr 0x3FE, MEMSIZE 1024 -> rsp_fault 1, rsp_rdata 0, bytes 0x3FE..0x3FF unchanged.
REQ-037 SHALL verify: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable 5 cycles, req_ready low until 1 cycle after handshake.
REQ-038 SHALL verify: reset asserted one cycle after a write accept (RD_LATENCY=3) -> all outputs 0 immediately, target bytes keep old value.
REQ-039 SHALL verify: read size 3 addr 0x11 -> fault 1 with MEM_PORT_CTRL_ALIGN_CHECK_EN; with the macro undefined -> bytes 0x11..0x18 assembled little-endian, fault 0.
